// File: rtl/mux2_rr_feeder_pkg.sv
// Shared types for the round-robin 2:1 feeder: FSM state encoding and
// source identifiers used for the last-served flag.
package mux2_rr_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GA   = 2'd1,
    ST_GB   = 2'd2
  } state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/mux2_rr_feeder_mux2_w.sv
// WIDTH-wide combinational 2:1 mux; s=0 passes a, s=1 passes b.
module mux2_w #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] o
);

  assign o = s ? b : a;

endmodule

// File: rtl/mux2_rr_feeder.sv
// Round-robin feeder for the 2:1 select mux. Arbitrates two valid/ready
// sources with a bounded burst per source, drives the mux select, and
// registers the selected word into a single output stage.
module mux2_rr_feeder
  import mux2_rr_feeder_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b,
  output logic             b_ready,
  output logic             s,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready
);

  localparam int            CW      = $clog2(BURST) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST - 1);

  state_e           state_q, state_d;
  src_e             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_q, s_d;
  logic [WIDTH-1:0] o_q;
  logic             ov_q;
  logic [WIDTH-1:0] mux_w;
  logic             load, a_xfer, b_xfer, grant_a, grant_b;

  // The output stage can take a word when empty or being drained this cycle.
  assign load    = !ov_q || o_ready;
  assign a_ready = load && (state_q == ST_GA);
  assign b_ready = load && (state_q == ST_GB);
  assign a_xfer  = a_valid && a_ready;
  assign b_xfer  = b_valid && b_ready;

  assign s       = s_q;
  assign o       = o_q;
  assign o_valid = ov_q;

  // s_q tracks the grant, so the mux always steers the granted source.
  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .a (a),
    .b (b),
    .s (s_q),
    .o (mux_w)
  );

  // Next-state logic: grant selection, burst counting, source switching.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Tie goes to whichever source was not served last.
        if (a_valid && b_valid) begin
          if (last_q == SRC_B) grant_a = 1'b1;
          else                 grant_b = 1'b1;
        end else if (a_valid) begin
          grant_a = 1'b1;
        end else if (b_valid) begin
          grant_b = 1'b1;
        end
      end
      ST_GA: begin
        // Count saturates so a lone source can stream forever without wrap.
        if (a_xfer && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CW'(1);
        if (b_valid && (!a_valid || (a_xfer && (cnt_q == CNT_MAX)))) grant_b = 1'b1;
        else if (!a_valid && !b_valid) state_d = ST_IDLE;
      end
      ST_GB: begin
        if (b_xfer && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CW'(1);
        if (a_valid && (!b_valid || (b_xfer && (cnt_q == CNT_MAX)))) grant_a = 1'b1;
        else if (!a_valid && !b_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant_a) begin
      state_d = ST_GA;
      cnt_d   = '0;
      last_d  = SRC_A;
      s_d     = 1'b0;
    end
    if (grant_b) begin
      state_d = ST_GB;
      cnt_d   = '0;
      last_d  = SRC_B;
      s_d     = 1'b1;
    end
  end

  // Control state registers; last starts at B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= SRC_B;
      cnt_q   <= '0;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
    end
  end

  // Single output stage: load on transfer, otherwise drain when accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q  <= '0;
      ov_q <= 1'b0;
    end else if (a_xfer || b_xfer) begin
      o_q  <= mux_w;
      ov_q <= 1'b1;
    end else begin
      ov_q <= ov_q && !o_ready;
    end
  end

endmodule

// File: tb/tb_mux2_rr_feeder.sv
// Bench for mux2_rr_feeder: directed scenarios plus randomized traffic,
// checked against a reference model of owner/streak arbitration and an
// in-order word scoreboard.
module tb_mux2_rr_feeder;

  localparam int W     = 4;
  localparam int BURST = 2;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, a_valid, b_valid, o_ready;
  logic [W-1:0] a, b;
  logic         a_ready, b_ready, s, o_valid;
  logic [W-1:0] o;

  logic         rst1, a1_valid, b1_valid, o1_ready;
  logic [W-1:0] a1, b1;
  logic         a1_ready, b1_ready, s1, o1_valid;
  logic [W-1:0] o1;

  mux2_rr_feeder #(.WIDTH(W), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a(a), .a_ready(a_ready),
    .b_valid(b_valid), .b(b), .b_ready(b_ready),
    .s(s), .o(o), .o_valid(o_valid), .o_ready(o_ready)
  );

  mux2_rr_feeder #(.WIDTH(W), .BURST(1)) dut1 (
    .clk(clk), .rst(rst1),
    .a_valid(a1_valid), .a(a1), .a_ready(a1_ready),
    .b_valid(b1_valid), .b(b1), .b_ready(b1_ready),
    .s(s1), .o(o1), .o_valid(o1_valid), .o_ready(o1_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source queues, hold flags and injection probabilities (percent).
  logic [W-1:0] qa[$], qb[$];
  bit           ha, hb;
  int           pa = 100, pb = 100;
  bit           rnd_ordy = 0;

  // Reference model: who owns the output port, who was served last,
  // length of the current streak, and the output register contents.
  int           m_own, m_last, m_cnt;
  logic         m_s, m_ov;
  logic [W-1:0] m_o;
  logic [W-1:0] exp_q[$];

  // Observation logs for directed scenarios.
  logic [W-1:0] olog[$];
  logic         slog[$];
  int           bt[$];
  int           cyc = 0;
  int           ar_cnt = 0;

  task automatic model_reset();
    m_own = 0; m_last = 2; m_cnt = 0; m_s = 1'b0; m_o = '0; m_ov = 1'b0;
    exp_q.delete();
  endtask

  task automatic m_grant(input int who);
    m_own = who; m_cnt = 0; m_last = who; m_s = (who == 2);
  endtask

  task automatic clear_logs();
    olog.delete(); slog.delete(); bt.delete(); ar_cnt = 0;
  endtask

  // One clock: present source words, check DUT at negedge, advance model.
  task automatic cycle();
    logic e_ar, e_br, ld, ax, bx;
    int   nxt;
    if (!ha && qa.size() > 0 && $urandom_range(99) < pa) ha = 1;
    if (!hb && qb.size() > 0 && $urandom_range(99) < pb) hb = 1;
    a_valid = ha; a = ha ? qa[0] : W'($urandom);
    b_valid = hb; b = hb ? qb[0] : W'($urandom);
    if (rnd_ordy) o_ready = ($urandom_range(99) < 70);
    @(negedge clk);
    ld   = !m_ov || o_ready;
    e_ar = ld && (m_own == 1);
    e_br = ld && (m_own == 2);
    chk("a_ready", a_ready, e_ar);
    chk("b_ready", b_ready, e_br);
    chk("s", s, m_s);
    chk("o_valid", o_valid, m_ov);
    chk("o", o, m_o);
    if (a_ready) ar_cnt++;
    if (o_valid && o_ready && !rst) begin
      olog.push_back(o);
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL o_spurious: observed word=%0h expected no word", o);
      end
      if (exp_q.size() > 0) chk("o_order", o, exp_q.pop_front());
    end
    ax = a_valid && e_ar;
    bx = b_valid && e_br;
    if (a_valid && a_ready) begin qa.pop_front(); ha = 0; slog.push_back(s); end
    if (b_valid && b_ready) begin qb.pop_front(); hb = 0; slog.push_back(s); bt.push_back(cyc); end
    if (rst) begin
      model_reset();
    end else begin
      if (ax) exp_q.push_back(a);
      if (bx) exp_q.push_back(b);
      if (ax)      begin m_o = a; m_ov = 1'b1; end
      else if (bx) begin m_o = b; m_ov = 1'b1; end
      else         m_ov = m_ov && !o_ready;
      case (m_own)
        0: begin
          nxt = 0;
          if (a_valid && b_valid) nxt = (m_last == 1) ? 2 : 1;
          else if (a_valid)       nxt = 1;
          else if (b_valid)       nxt = 2;
          if (nxt != 0) m_grant(nxt);
        end
        1: begin
          if (b_valid && (!a_valid || (ax && m_cnt == BURST - 1))) m_grant(2);
          else if (!a_valid && !b_valid) m_own = 0;
          else if (ax && m_cnt < BURST - 1) m_cnt++;
        end
        default: begin
          if (a_valid && (!b_valid || (bx && m_cnt == BURST - 1))) m_grant(1);
          else if (!a_valid && !b_valid) m_own = 0;
          else if (bx && m_cnt < BURST - 1) m_cnt++;
        end
      endcase
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || exp_q.size() > 0 || m_ov) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL %s: drain used %0d cycles, limit %0d", tag, n, budget);
    end
  endtask

  initial begin
    logic [W-1:0] tie_o[6] = '{4'h3, 4'h4, 4'h9, 4'hA, 4'h5, 4'hB};
    logic         tie_s[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] held;
    logic [W-1:0] pend1[$];
    int           glog[$];
    logic         s1log[$];
    int           start, n;
    bit           a_acc, b_acc;

    // Reset with both sources asserting valid.
    rst = 1; o_ready = 1; a_valid = 1; b_valid = 1; a = '0; b = '0;
    rst1 = 1; a1_valid = 0; b1_valid = 0; a1 = '0; b1 = '0; o1_ready = 1;
    ha = 0; hb = 0;
    @(posedge clk); #1;
    model_reset();
    qa = '{4'h3, 4'h4, 4'h5};
    qb = '{4'h9, 4'hA, 4'hB};
    cycle();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o", o, 0);
    chk("rst_s", s, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);

    // Tie from IDLE with both sources streaming.
    rst = 0; clear_logs();
    n = 0;
    while (olog.size() < 6 && n < 40) begin cycle(); n++; end
    chk("tie_count", olog.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < olog.size()) chk($sformatf("tie_o%0d", k), olog[k], tie_o[k]);
      if (k < slog.size()) chk($sformatf("tie_s%0d", k), slog[k], tie_s[k]);
    end
    repeat (3) cycle();

    // Single source B: one bubble, then back-to-back.
    clear_logs();
    start = cyc;
    qb = '{4'h7, 4'h8, 4'h9};
    n = 0;
    while (olog.size() < 3 && n < 30) begin cycle(); n++; end
    chk("single_count", olog.size(), 3);
    chk("single_a_ready_seen", ar_cnt, 0);
    if (bt.size() == 3) begin
      chk("single_bubble", bt[0] - start, 1);
      chk("single_b2b_1", bt[1] - bt[0], 1);
      chk("single_b2b_2", bt[2] - bt[1], 1);
    end
    for (int k = 0; k < 3 && k < olog.size(); k++) begin
      chk($sformatf("single_o%0d", k), olog[k], 4'h7 + W'(k));
      chk($sformatf("single_s%0d", k), slog[k], 1);
    end
    repeat (3) cycle();

    // Backpressure mid-stream.
    clear_logs();
    qa = '{4'h1, 4'h2, 4'h3, 4'h4};
    qb = '{4'h5, 4'h6, 4'h7};
    repeat (3) cycle();
    held = o;
    chk("bp_pre_valid", o_valid, 1);
    o_ready = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("bp_hold_o%0d", k), o, held);
      chk($sformatf("bp_valid%0d", k), o_valid, 1);
      chk($sformatf("bp_a_ready%0d", k), a_ready, 0);
      chk($sformatf("bp_b_ready%0d", k), b_ready, 0);
    end
    o_ready = 1;
    drain(60, "bp_drain");
    chk("bp_total", olog.size(), 7);

    // Park the main DUT in reset while the BURST=1 instance runs.
    rst = 1;
    cycle();
    @(posedge clk); #1;
    rst1 = 0;
    a1 = W'($urandom); b1 = W'($urandom);
    a1_valid = 1; b1_valid = 1; o1_ready = 1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (o1_valid) begin
        checks++;
        assert (pend1.size() > 0) else begin
          errors++;
          $error("FAIL b1_spurious: observed word=%0h expected no word", o1);
        end
        if (pend1.size() > 0) chk("b1_o", o1, pend1.pop_front());
      end
      a_acc = a1_ready;
      b_acc = b1_ready;
      if (a1_ready) begin glog.push_back(0); s1log.push_back(s1); pend1.push_back(a1); end
      if (b1_ready) begin glog.push_back(1); s1log.push_back(s1); pend1.push_back(b1); end
      @(posedge clk); #1;
      if (a_acc) a1 = W'($urandom);
      if (b_acc) b1 = W'($urandom);
    end
    chk("b1_enough", glog.size() >= 8, 1);
    for (int k = 0; k < 8 && k < glog.size(); k++) begin
      chk($sformatf("b1_grant%0d", k), glog[k], k % 2);
      chk($sformatf("b1_s%0d", k), s1log[k], k % 2);
    end
    rst1 = 1; a1_valid = 0; b1_valid = 0;

    // Reset mid-burst while B holds the grant with a full output stage.
    cycle();
    rst = 0; o_ready = 1;
    clear_logs();
    qb = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    repeat (2) cycle();
    chk("mid_o_valid", o_valid, 1);
    chk("mid_b_ready", b_ready, 1);
    chk("mid_s", s, 1);
    qa = '{4'hC};
    rst = 1;
    cycle();
    chk("mid_rst_o_valid", o_valid, 0);
    chk("mid_rst_a_ready", a_ready, 0);
    chk("mid_rst_b_ready", b_ready, 0);
    chk("mid_rst_s", s, 0);
    rst = 0;
    cycle();
    chk("mid_first_a_ready", a_ready, 1);
    chk("mid_first_b_ready", b_ready, 0);
    chk("mid_first_s", s, 0);
    drain(60, "mid_drain");

    // Randomized traffic with random backpressure.
    pa = 60; pb = 60; rnd_ordy = 1;
    for (int k = 0; k < 40; k++) begin
      qa.push_back(W'($urandom));
      qb.push_back(W'($urandom));
    end
    drain(1500, "rand_drain");
    rnd_ordy = 0; o_ready = 1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
